rr_grant_sched: RTL and testbench

- Round-robin arbiter/scheduler sharing one resource between N requesters.
- Resource examples: the shared n-bit encoder datapath or a downstream bus.
- Selects one requester per tenure using a rotating-priority search; the search is a priority encode starting at a moving pointer.
- Presents the winner as a one-hot grant and a binary index, holds it until release, then advances priority.

---
 rtl/rr_grant_sched.sv | 121 ++++++++++++
 tb/tb_rr_grant_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler: one tenure at a time, rotating priority, one idle cycle between
// grants. Define RR_GRANT_SCHED_TIMEOUT_EN to bound each tenure to HOLD_MAX cycles.
// `release` is a reserved word, so the release pulse input is named rel.
module rr_grant_sched #(
  parameter int unsigned N        = 8,
  parameter int unsigned W        = 3,
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         rel,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid,
  output logic         timeout
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [W:0]   NumReq  = (W+1)'(N);
  localparam logic [W-1:0] LastIdx = W'(N-1);

  state_e         state_q;
  logic [W-1:0]   ptr_q;
  logic [N-1:0]   gnt_q;
  logic [W-1:0]   gnt_idx_q;
  logic           gnt_valid_q;
  logic           timeout_q;

  logic [N-1:0]   req_rot;
  logic [W-1:0]   win_off;
  logic [W:0]     win_sum;
  logic [W-1:0]   win_idx;
  logic [W-1:0]   ptr_next;
  logic           rel_end;
  logic           hold_expired;
  logic           tenure_end;

  // Rotate so that bit 0 of req_rot is the requester at the pointer.
  assign req_rot = N'({req, req} >> ptr_q);

  always_comb begin
    win_off = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_rot[i]) win_off = W'(i);
    end
  end

  assign win_sum  = {1'b0, ptr_q} + {1'b0, win_off};
  assign win_idx  = (win_sum >= NumReq) ? W'(win_sum - NumReq) : W'(win_sum);
  assign ptr_next = (gnt_idx_q == LastIdx) ? '0 : gnt_idx_q + 1'b1;

  // A dropped request from the holder ends the tenure just like rel.
  assign rel_end    = rel || !req[gnt_idx_q];
  assign tenure_end = rel_end || hold_expired;

`ifdef RR_GRANT_SCHED_TIMEOUT_EN
  localparam int unsigned      CntW    = $clog2(HOLD_MAX + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(HOLD_MAX - 1);

  logic [CntW-1:0] cnt_q;

  // Counter is 0 in the first granted cycle, so expiry lands after HOLD_MAX granted cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == StIdle || tenure_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hold_expired = (state_q == StBusy) && (cnt_q == CntLast);
`else
  logic unused_hold_max;
  assign unused_hold_max = (HOLD_MAX == 0);
  assign hold_expired    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|req) begin
            state_q     <= StBusy;
            gnt_q       <= N'(1) << win_idx;
            gnt_idx_q   <= win_idx;
            gnt_valid_q <= 1'b1;
          end
        end
        StBusy: begin
          if (tenure_end) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= ptr_next;
            timeout_q   <= hold_expired && !rel_end;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_sched.sv
// Self-checking bench for rr_grant_sched: a cycle model pushes expected outputs to a queue
// as inputs are applied; each entry is popped and compared one edge later.
module tb_rr_grant_sched;

  localparam int unsigned N       = 8;
  localparam int unsigned W       = 3;
  localparam int unsigned HoldMax = 15;
`ifdef RR_GRANT_SCHED_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         rel;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_idx;
  logic         gnt_valid;
  logic         timeout;

  rr_grant_sched #(.N(N), .W(W), .HOLD_MAX(HoldMax)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [W-1:0] idx;
    logic         valid;
    logic         tmo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit          m_busy;
  int unsigned m_ptr;
  int unsigned m_idx;
  int unsigned m_held;
  bit          m_tmo;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned pick(input logic [N-1:0] r, input int unsigned p);
    for (int k = 0; k < int'(N); k++) begin
      int unsigned c;
      c = (p + k) % N;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_idx = 0; m_held = 0; m_tmo = 0;
    exp_q.delete();
  endtask

  // Advance the model by one edge, push its prediction, then compare after the edge.
  task automatic step(input string tag);
    exp_t e;
    if (!m_busy) begin
      m_tmo = 0;
      if (req != '0) begin
        m_idx  = pick(req, m_ptr);
        m_busy = 1;
        m_held = 1;
      end
    end else if (rel || !req[m_idx]) begin
      m_busy = 0; m_ptr = (m_idx + 1) % N; m_tmo = 0;
    end else if (TmoEn && m_held == HoldMax) begin
      m_busy = 0; m_ptr = (m_idx + 1) % N; m_tmo = 1;
    end else begin
      m_held++;
      m_tmo = 0;
    end
    e.gnt   = m_busy ? N'(1) << m_idx : '0;
    e.idx   = m_busy ? W'(m_idx) : '0;
    e.valid = m_busy;
    e.tmo   = m_tmo;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq({tag, "_gnt"},   32'(gnt),       32'(e.gnt));
    check_eq({tag, "_idx"},   32'(gnt_idx),   32'(e.idx));
    check_eq({tag, "_valid"}, 32'(gnt_valid), 32'(e.valid));
    check_eq({tag, "_tmo"},   32'(timeout),   32'(e.tmo));
  endtask

  // Called just after an edge; checks the asynchronous clear before the next edge.
  task automatic reset_dut(input string tag);
    rst_n = 1'b0;
    #2;
    check_eq({tag, "_async_gnt"},   32'(gnt),       32'd0);
    check_eq({tag, "_async_valid"}, 32'(gnt_valid), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1);
  end

  initial begin
    int pulses;
    rst_n = 1'b0;
    req   = '1;
    rel   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_gnt",   32'(gnt),       32'd0);
    check_eq("reset_idx",   32'(gnt_idx),   32'd0);
    check_eq("reset_valid", 32'(gnt_valid), 32'd0);
    check_eq("reset_tmo",   32'(timeout),   32'd0);
    rst_n = 1'b1;
    req   = '0;
    repeat (5) step("idle");

    // Single requester with the idle gap between tenures
    req = 8'b0001_0000;
    step("single");
    check_eq("single_gnt10", 32'(gnt), 32'h10);
    check_eq("single_idx4",  32'(gnt_idx), 32'd4);
    rel = 1'b1;
    step("single_rel");
    rel = 1'b0;
    check_eq("single_gap", 32'(gnt_valid), 32'd0);
    step("single_regrant");
    check_eq("single_again", 32'(gnt), 32'h10);

    // Mid-tenure reset drops the grant at once, pointer back to 0
    reset_dut("midbusy");

    // Rotation 0..7,0 with all requesting
    req = '1;
    for (int t = 0; t < 9; t++) begin
      step("rot");
      check_eq("rot_seq", 32'(gnt_idx), 32'(t % 8));
      rel = 1'b1;
      step("rot_rel");
      rel = 1'b0;
      check_eq("rot_gap", 32'(gnt_valid), 32'd0);
    end

    // Wrap search: finish index 6 (ptr=7), then 0, then 2
    req = 8'b0100_0000;
    step("wrap6");
    check_eq("wrap_idx6", 32'(gnt_idx), 32'd6);
    rel = 1'b1; step("wrap6_rel"); rel = 1'b0;
    req = 8'b0000_0101;
    step("wrap0");
    check_eq("wrap_idx0", 32'(gnt_idx), 32'd0);
    rel = 1'b1; step("wrap0_rel"); rel = 1'b0;
    step("wrap2");
    check_eq("wrap_idx2", 32'(gnt_idx), 32'd2);
    rel = 1'b1; step("wrap2_rel"); rel = 1'b0;

    // Drop-as-release on index 3; other bits toggling while busy do nothing
    req = 8'b0000_1000;
    step("drop_grant");
    check_eq("drop_idx3", 32'(gnt_idx), 32'd3);
    req = 8'b0010_1000; step("drop_tog1");
    check_eq("drop_hold", 32'(gnt), 32'h08);
    req = 8'b0000_1000; step("drop_tog2");
    req = 8'b0000_0000; step("drop");
    check_eq("drop_gnt0", 32'(gnt), 32'd0);
    req = 8'b0001_1000; step("drop_next");
    check_eq("drop_ptr4", 32'(gnt_idx), 32'd4);

    // Release and new requests together: release first, arbitration next cycle
    req = '1; rel = 1'b1;
    step("simul_rel");
    rel = 1'b0;
    check_eq("simul_gap", 32'(gnt_valid), 32'd0);
    step("simul_next");
    check_eq("simul_idx5", 32'(gnt_idx), 32'd5);
    rel = 1'b1; step("simul_rel2"); rel = 1'b0;

    // Long hold on requester 0: bounded only when the timeout is built
    reset_dut("tmo_pre");
    req = 8'h01;
    pulses = 0;
    step("hold");
    for (int c = 0; c < 40; c++) begin
      step("hold");
      if (timeout === 1'b1) pulses++;
    end
    check_eq("hold_pulses", 32'(pulses), TmoEn ? 32'd2 : 32'd0);
    rel = 1'b1; step("hold_rel"); rel = 1'b0;
    req = '0; step("hold_idle");

`ifdef RR_GRANT_SCHED_TIMEOUT_EN
    // Expiry after exactly HoldMax granted cycles
    reset_dut("tmo");
    req = 8'h01;
    step("tmo_grant");
    for (int c = 1; c < int'(HoldMax); c++) step("tmo_wait");
    check_eq("tmo_still_held", 32'(gnt), 32'h01);
    step("tmo_fire");
    check_eq("tmo_pulse", 32'(timeout), 32'd1);
    check_eq("tmo_dropped", 32'(gnt_valid), 32'd0);
    step("tmo_regrant");
    check_eq("tmo_one_cycle", 32'(timeout), 32'd0);
    // Release on the last allowed cycle wins over the timeout
    for (int c = 1; c < int'(HoldMax); c++) step("tmo_wait2");
    rel = 1'b1;
    step("tmo_rel15");
    rel = 1'b0;
    check_eq("tmo_rel_wins", 32'(timeout), 32'd0);
    req = '0; step("tmo_idle");
`endif

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      rel = ($urandom_range(0, 4) == 0);
      step("rand");
    end
    rel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
